// File: rtl/spi_slave_xcvr_if.sv
// Pin-side and datapath-side signals of the SPI slave transceiver, bundled so
// the endpoint and its driver share one definition.
interface spi_slave_xcvr_if #(
  parameter int unsigned WIDTH = 12
);
  logic             sclk;
  logic             cs;
  logic             mosi;
  logic             miso;
  logic [WIDTH-1:0] tx_data;
  logic             tx_load;
  logic [WIDTH-1:0] rx_data;
  logic             done;
  logic             frame_err;
  logic             busy;

  modport slave (
    input  sclk, cs, mosi, tx_data, tx_load,
    output miso, rx_data, done, frame_err, busy
  );

  modport master (
    output sclk, cs, mosi, tx_data, tx_load,
    input  miso, rx_data, done, frame_err, busy
  );
endinterface

// File: rtl/spi_slave_xcvr.sv
// Oversampled mode-0 SPI slave: receives one LSB-first WIDTH-bit frame per cs window.
// Define SPI_SLAVE_MISO_EN to compile in the reply buffer and miso shifter.
module spi_slave_xcvr #(
  parameter int unsigned WIDTH       = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic             clk,
  input logic             rst,
  spi_slave_xcvr_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_hist_q, cs_hist_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]       rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0]       rx_data_q, rx_data_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      sclk_hist_q <= sclk_s;
      cs_hist_q   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  // The cs history resets low, so a cs held low through reset never looks like a fall.
  assign cs_rise   = cs_s & ~cs_hist_q;
  assign cs_fall   = ~cs_s & cs_hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        // A full count wins over a simultaneous cs rise: the frame is complete.
        if (cnt_q == CW'(WIDTH)) begin
          state_d   = WAIT;
          rx_data_d = rx_shift_q;
          done_d    = 1'b1;
        end else if (cs_rise) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (sclk_rise) begin
          for (int unsigned i = 0; i < WIDTH; i++) begin
            if (cnt_q == CW'(i)) rx_shift_d[i] = mosi_s;
          end
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT: begin
        if (cs_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.done      = done_q;
  assign bus.frame_err = err_q;
  assign bus.busy      = (state_q == SHIFT);

`ifdef SPI_SLAVE_MISO_EN
  logic [WIDTH-1:0] reply_q, reply_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reply_q    <= '0;
      tx_shift_q <= '0;
    end else begin
      reply_q    <= reply_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  // A load coinciding with frame start bypasses the buffer so the new word goes out.
  always_comb begin
    reply_d    = bus.tx_load ? bus.tx_data : reply_q;
    tx_shift_d = tx_shift_q;
    if (state_q == IDLE && cs_fall) begin
      tx_shift_d = reply_d;
    end else if (state_q == SHIFT && sclk_fall) begin
      tx_shift_d = tx_shift_q >> 1;
    end
  end

  assign bus.miso = tx_shift_q[0];
`else
  assign bus.miso = 1'b0;
`endif
endmodule

// File: doc/spi_slave_xcvr.md
# spi_slave_xcvr

Full-duplex SPI slave endpoint: the far end of the 12-bit SPI link driven by the project's SPI master. Oversamples `sclk`, `cs` and `mosi` on the local system clock, deserialises one WIDTH-bit frame per `cs` assertion and presents it on `rx_data` with a one-cycle `done` pulse. Optionally shifts a preloaded reply word out on `miso` in the same frame. Sits between the SPI pins and the local register/datapath logic.

## Interface
- `WIDTH`, default 12: frame length in bits.
- `SYNC_STAGES`, default 2: synchroniser depth for `sclk`/`cs`/`mosi`; legal values 2–3.
- `clk` input, 1 bit: system clock.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `sclk` input, 1 bit: SPI clock from master, asynchronous to `clk`.
- `cs` input, 1 bit: chip select, active-low, asynchronous.
- `mosi` input, 1 bit: serial data from master.
- `miso` output, 1 bit: serial reply data to master.
- `tx_data` input, WIDTH bits: reply word for the next frame.
- `tx_load` input, 1 bit: capture `tx_data` into the reply buffer on this `clk` edge.
- `rx_data` output, WIDTH bits: last complete received frame.
- `done` output, 1 bit: one-cycle pulse when `rx_data` updates.
- `frame_err` output, 1 bit: one-cycle pulse on an aborted frame.
- `busy` output, 1 bit: high while a frame is in progress (state SHIFT).

## Operation
- Signal conditioning: `sclk`, `cs` and `mosi` each pass through SYNC_STAGES flops. Edges are detected on the synchronised `sclk` and `cs` using one extra history flop.
- Bit order: LSB first. Mode 0: sample on `sclk` rising, `miso` changes on `sclk` falling.
- State IDLE:
  - On a synchronised `cs` falling edge: go to SHIFT, clear the bit counter, load the TX shift register from the reply buffer.
- State SHIFT:
  - On each synchronised `sclk` rising edge: shift the synchronised `mosi` into RX shift register bit [counter], then increment the counter.
  - When the counter reaches WIDTH: copy the RX shift register to `rx_data`, pulse `done` on the next cycle, go to WAIT.
  - If `cs` rises with counter < WIDTH: pulse `frame_err`, leave `rx_data` unchanged, go to IDLE.
- State WAIT:
  - Ignore all further `sclk` edges.
  - On `cs` rising: go to IDLE (no error).
- Counter is $clog2(WIDTH+1) bits wide and never wraps; bits beyond WIDTH are dropped.
- `tx_load` is accepted in any state and updates the reply buffer only. The active frame's TX shift register is not affected.
- `tx_load` in the same cycle as the `cs` falling-edge detection: the new `tx_data` is the word shifted out.
- After reset release with `cs` already low, stay in IDLE until `cs` has been seen high. There is no mid-frame join.
- `rst` asserted mid-frame: all state and outputs return to reset values immediately; the partial frame is discarded with no `done` and no `frame_err`.

## Timing
- Reset values: `miso`=0, `rx_data`=0, `done`=0, `frame_err`=0, `busy`=0. Reply buffer, shift registers, counter and synchronisers are all 0. State is IDLE.
- Input latency: pin change to internal edge detection takes SYNC_STAGES+1 `clk` cycles.
- `done` rises SYNC_STAGES+2 cycles after the WIDTH-th `sclk` rising edge at the pin. `rx_data` is valid in the same cycle and holds until the next good frame.
- `miso` presents TX bit 0 one cycle after `cs` fall detection, then advances one bit per detected `sclk` falling edge.
- Master constraint: `sclk` high and low phases must each be at least SYNC_STAGES+2 `clk` periods; `cs` setup to the first `sclk` rise must be at least the same.
- `busy` is high from the cycle after `cs` fall detection through the last sampled bit.

## Configuration
- `SPI_SLAVE_MISO_EN` defined: reply buffer, TX shift register and `miso` logic are compiled in, as described above.
- `SPI_SLAVE_MISO_EN` undefined: `miso` is tied to 0; `tx_data` and `tx_load` are ignored; the receive path is unchanged.

## Test plan
- Reset, then frame `mosi`=12'hA5C LSB first, `sclk` half-period 8 `clk` cycles -> `rx_data`=12'hA5C; one `done` pulse; `frame_err`=0.
- With `SPI_SLAVE_MISO_EN`: `tx_load` with `tx_data`=12'h3C9, then a frame -> bits sampled on `miso` at `sclk` rises equal 12'h3C9 LSB first; the concurrent receive of 12'h001 is correct.
- `cs` rises after 7 bits of 12'hFFF -> `frame_err` pulses once; `done` stays 0; `rx_data` keeps its previous value; the next full frame of 12'h123 is received correctly.
- 15 `sclk` pulses in one `cs` window sending 12'h0F0 then 3 extra 1-bits -> `rx_data`=12'h0F0; exactly one `done` pulse.
- `rst` asserted after 6 bits, released while `cs` is still low, then the master finishes the frame -> no `done`, `rx_data`=0; the following full frame 12'h7E1 is received.
- 10 back-to-back random frames, each with a fresh `tx_load` in the same cycle as `cs` fall detection -> every `rx_data` matches; every `miso` word equals that frame's newly loaded value.
